// File: rtl/fetch_queue_pkg.sv
// fetch_pkg: shared constants, entry type and pointer-width helper for fetch_queue
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: first-word-fall-through prefetch FIFO of {instr, pc} with flush; FETCH_QUEUE_BYPASS_EN adds an empty-queue bypass
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  logic [DATA_WIDTH-1:0]      enq_instr_i,
  input  logic [DATA_WIDTH-1:0]      enq_pc_i,
  output logic                       deq_valid_o,
  input  logic                       deq_ready_i,
  output logic [DATA_WIDTH-1:0]      deq_instr_o,
  output logic [DATA_WIDTH-1:0]      deq_pc_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_entry_t r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic w_empty, w_byp, w_enq, w_deq;
  fetch_entry_t w_head;
  assign w_empty = (r_count == '0);
`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_byp = w_empty && enq_valid_i && !flush_i;
`else
  assign w_byp = 1'b0;
`endif
  assign w_head = r_mem[r_rd_ptr];
  assign enq_ready_o = (r_count != CW'(DEPTH));
  assign deq_valid_o = !w_empty || w_byp;
  assign deq_instr_o = w_byp ? enq_instr_i : !w_empty ? DATA_WIDTH'(w_head.instr) : DATA_WIDTH'(NOP_INSTR);
  assign deq_pc_o = w_byp ? enq_pc_i : !w_empty ? DATA_WIDTH'(w_head.pc) : '0;
  assign count_o = r_count;
  // a bypassed entry consumed in the same cycle never touches storage
  assign w_enq = enq_valid_i && enq_ready_o && !(w_byp && deq_ready_i);
  assign w_deq = !w_empty && deq_ready_i;
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wr_ptr] <= '{instr: XLEN'(enq_instr_i), pc: XLEN'(enq_pc_i)};
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (r_count <= CW'(DEPTH));
      assert (!(w_deq && w_empty));
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus against a queue-based reference model
module tb_fetch_queue;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, flush = 0, ev = 0, dr = 0;
  logic [31:0] instr = 0, pc = 0;
  logic er, dv;
  logic [31:0] di, dp;
  logic [2:0] cnt;
  int tests = 0, fails = 0;
  bit model_ok = 0;
  logic [63:0] q[$];
  always #5 clk = ~clk;
  fetch_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .enq_valid_i(ev), .enq_ready_o(er),
    .enq_instr_i(instr), .enq_pc_i(pc), .deq_valid_o(dv), .deq_ready_i(dr),
    .deq_instr_o(di), .deq_pc_o(dp), .count_o(cnt)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic f, input logic v, input logic [31:0] ins,
                      input logic [31:0] p, input logic d);
    bit empty, byp;
    logic [63:0] head;
    rst = r; flush = f; ev = v; instr = ins; pc = p; dr = d;
    #1;
    empty = (q.size() == 0);
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = empty && v && !f;
`else
    byp = 0;
`endif
    head = byp ? {ins, p} : empty ? {32'h0000_0013, 32'h0} : q[0];
    if (model_ok) begin
      check("enq_ready", 64'(er), 64'(q.size() != DEPTH));
      check("deq_valid", 64'(dv), 64'(!empty || byp));
      check("deq_instr", 64'(di), 64'(head[63:32]));
      check("deq_pc", 64'(dp), 64'(head[31:0]));
      check("count", 64'(cnt), 64'(q.size()));
    end
    @(posedge clk);
    if (r || f) q.delete();
    else if (!(byp && d)) begin
      bit full;
      full = (q.size() == DEPTH);
      if (!empty && d) void'(q.pop_front());
      if (v && !full) q.push_back({ins, p});
    end
    if (r) model_ok = 1;
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h00500093, 32'h0, 0);
    step(0, 0, 1, 32'h00A00113, 32'h4, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h100 + i, 32'(4 * i), 0);
    step(0, 0, 1, 32'h104, 32'h10, 0);
    step(0, 0, 1, 32'h104, 32'h10, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h200, 32'h0, 0);
    for (int i = 1; i <= 10; i++) step(0, 0, 1, 32'h200 + i, 32'(4 * i), 1);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h300 + i, 32'(4 * i), 0);
    step(0, 1, 1, 32'h340, 32'h40, 1);
    step(0, 0, 1, 32'h380, 32'h80, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h400, 32'h100, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, 1'($urandom),
           $urandom, $urandom, $urandom_range(0, 2) != 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
